// File: rtl/gemm_output_collector_pkg.sv
// Shared types and helpers for the GEMM output collector and its harness.
package gemm_output_collector_pkg;

   // Collector control states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      CAPTURE = 2'd2,
      DRAIN   = 2'd3
   } collector_state_t;

   // Input-to-output latency of the fixed-weight systolic GEMM: one
   // SA_SIZE skew to load the wavefront plus one SA_SIZE pass through the
   // array. Used by the GEMM verification harness as well.
   function automatic int gemm_latency(input int sa_size);
      return 2 * sa_size;
   endfunction

endpackage

// File: rtl/gemm_output_collector_row_buffer.sv
// Result-matrix storage: ROWS x SA_SIZE register array, one write port,
// one registered read port. The read register is the collector's out_data.
module gemm_row_buffer #(
   parameter int ROWS    = 2,
   parameter int SA_SIZE = 4,
   parameter int W       = 8,
   parameter int AW      = 1
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        wr_en,
   input  logic [AW-1:0]               wr_addr,
   input  logic [SA_SIZE-1:0][W-1:0]   wr_data,
   input  logic                        rd_en,
   input  logic [AW-1:0]               rd_addr,
   output logic [SA_SIZE-1:0][W-1:0]   rd_data
);

   logic [ROWS-1:0][SA_SIZE-1:0][W-1:0] mem;

   // Row storage; contents are don't-care after reset so no reset here.
   always_ff @(posedge clk) begin
      for (int r = 0; r < ROWS; r++) begin
         if (wr_en && (wr_addr == AW'(r))) mem[r] <= wr_data;
      end
   end

   // Registered read, loaded only on request so it holds while stalled.
   // The bypass lets a row being written this cycle be read at once, which
   // matters when the last captured row is also row 0 (single-row batch).
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
      end
   end

endmodule

// File: rtl/gemm_output_collector.sv
// Collects INPUT_SIZE result vectors from the systolic GEMM at its fixed
// latency after a start pulse, then drains them one row per handshake.
module gemm_output_collector
   import gemm_output_collector_pkg::*;
#(
   parameter int SA_SIZE                = 4,
   parameter int INPUT_SIZE             = 2,
   parameter int WEIGHT_ACTIVATION_SIZE = 8,
   localparam int ROW_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
) (
   input  logic                                               clk,
   input  logic                                               resetn,
   input  logic                                               start,
   input  logic                                               in_valid,
   input  logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]     in_data,
   output logic                                               busy,
   output logic                                               out_valid,
   input  logic                                               out_ready,
   output logic [SA_SIZE-1:0][WEIGHT_ACTIVATION_SIZE-1:0]     out_data,
   output logic [ROW_W-1:0]                                   out_row,
   output logic                                               out_last,
   output logic                                               err_start_dropped,
   output logic                                               err_invalid_capture
);

   localparam int LATENCY = gemm_latency(SA_SIZE);
   localparam int CNT_W   = $clog2(LATENCY);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(INPUT_SIZE - 1);

   collector_state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [ROW_W-1:0] row;
   logic             wr_en;
   logic             rd_en;
   logic [ROW_W-1:0] rd_addr;
   logic             last_cap;
   logic             hs;
   logic             start_drop;

   // Next-state and buffer control decode.
   always_comb begin
      state_nxt  = state;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      rd_addr    = '0;
      hs         = out_valid && out_ready;
      last_cap   = (state == CAPTURE) && (row == LAST_ROW);
      start_drop = start && (state != IDLE);
      case (state)
         IDLE: begin
            if (start) state_nxt = WAIT;
         end
         WAIT: begin
            // Leaving on cnt==1 puts the first capture exactly LATENCY
            // cycles after start; cnt reads 0 in the first CAPTURE cycle.
            if (cnt == CNT_W'(1)) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            wr_en = 1'b1;
            if (last_cap) begin
               state_nxt = DRAIN;
               rd_en     = 1'b1;
               rd_addr   = '0;
            end
         end
         DRAIN: begin
            if (hs) begin
               if (out_last) begin
                  state_nxt = IDLE;
               end else begin
                  rd_en   = 1'b1;
                  rd_addr = out_row + ROW_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Latency/row counters, registered drain outputs and sticky error flags.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt                 <= '0;
         row                 <= '0;
         out_valid           <= 1'b0;
         out_row             <= '0;
         out_last            <= 1'b0;
         err_start_dropped   <= 1'b0;
         err_invalid_capture <= 1'b0;
      end else begin
         if (start_drop) err_start_dropped <= 1'b1;
         case (state)
            IDLE: begin
               if (start) cnt <= CNT_W'(LATENCY - 1);
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               row <= '0;
            end
            CAPTURE: begin
               // The row is stored regardless; a gap in in_valid is only flagged.
               if (!in_valid) err_invalid_capture <= 1'b1;
               if (last_cap) begin
                  row       <= '0;
                  out_valid <= 1'b1;
                  out_row   <= '0;
                  out_last  <= (LAST_ROW == '0);
               end else begin
                  row <= row + ROW_W'(1);
               end
            end
            DRAIN: begin
               if (hs) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                  end else begin
                     out_row  <= out_row + ROW_W'(1);
                     out_last <= ((out_row + ROW_W'(1)) == LAST_ROW);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

   gemm_row_buffer #(
      .ROWS    (INPUT_SIZE),
      .SA_SIZE (SA_SIZE),
      .W       (WEIGHT_ACTIVATION_SIZE),
      .AW      (ROW_W)
   ) u_buf (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (wr_en),
      .wr_addr (row),
      .wr_data (in_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (out_data)
   );

endmodule

// File: tb/tb_gemm_output_collector.sv
// Directed bench for gemm_output_collector: a 2x2 instance for the single
// batch corner cases and a 4x4 / 3-row instance for back-to-back batches.
module tb_gemm_output_collector;

   localparam int W    = 8;
   localparam int SA_A = 2, IN_A = 2, L_A = 4;
   localparam int SA_B = 4, IN_B = 3, L_B = 8;

   typedef logic [SA_A-1:0][W-1:0] row_a_t;
   typedef logic [SA_B-1:0][W-1:0] row_b_t;

   // One batch on the 2x2 instance: activations, hand-computed results and
   // the corner-case knobs with their expected error flags.
   typedef struct {
      row_a_t act0, act1, res0, res1;
      int     stall;
      int     start2;
      bit     start_last;
      bit     valid;
      bit     pre_reset;
      bit     exp_sd;
      bit     exp_ic;
   } case_a_t;

   typedef struct {
      row_b_t act [IN_B];
      row_b_t res [IN_B];
   } case_b_t;

   localparam int WA [2][2] = '{'{3, 0}, '{0, 2}};
   localparam int WB [4][4] = '{'{1, 2, 0, 1},
                                '{0, 1, 3, 0},
                                '{2, 0, 1, 1},
                                '{1, 1, 0, 2}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic   resetn_a, start_a, in_valid_a, busy_a, out_valid_a, out_ready_a;
   logic   out_last_a, err_sd_a, err_ic_a;
   row_a_t in_data_a, out_data_a;
   logic   out_row_a;

   logic   resetn_b, start_b, in_valid_b, busy_b, out_valid_b, out_ready_b;
   logic   out_last_b, err_sd_b, err_ic_b;
   row_b_t in_data_b, out_data_b;
   logic [1:0] out_row_b;

   gemm_output_collector #(.SA_SIZE(SA_A), .INPUT_SIZE(IN_A), .WEIGHT_ACTIVATION_SIZE(W)) dut_a (
      .clk(clk), .resetn(resetn_a), .start(start_a), .in_valid(in_valid_a), .in_data(in_data_a),
      .busy(busy_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
      .out_row(out_row_a), .out_last(out_last_a), .err_start_dropped(err_sd_a),
      .err_invalid_capture(err_ic_a));

   gemm_output_collector #(.SA_SIZE(SA_B), .INPUT_SIZE(IN_B), .WEIGHT_ACTIVATION_SIZE(W)) dut_b (
      .clk(clk), .resetn(resetn_b), .start(start_b), .in_valid(in_valid_b), .in_data(in_data_b),
      .busy(busy_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
      .out_row(out_row_b), .out_last(out_last_b), .err_start_dropped(err_sd_b),
      .err_invalid_capture(err_ic_b));

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
   endtask

   function automatic row_a_t p2(input int e0, input int e1);
      row_a_t r;
      r[0] = 8'(e0);
      r[1] = 8'(e1);
      return r;
   endfunction

   function automatic row_b_t p4(input int e0, input int e1, input int e2, input int e3);
      row_b_t r;
      r[0] = 8'(e0);
      r[1] = 8'(e1);
      r[2] = 8'(e2);
      r[3] = 8'(e3);
      return r;
   endfunction

   // GEMM models: y[j] = sum_i x[i] * w[i][j], truncated to the element width.
   function automatic row_a_t gemm_a(input row_a_t x);
      row_a_t y;
      for (int j = 0; j < SA_A; j++) begin
         int acc = 0;
         for (int i = 0; i < SA_A; i++) acc += int'(x[i]) * WA[i][j];
         y[j] = 8'(acc);
      end
      return y;
   endfunction

   function automatic row_b_t gemm_b(input row_b_t x);
      row_b_t y;
      for (int j = 0; j < SA_B; j++) begin
         int acc = 0;
         for (int i = 0; i < SA_B; i++) acc += int'(x[i]) * WB[i][j];
         y[j] = 8'(acc);
      end
      return y;
   endfunction

   // Off-window GEMM output: distinct junk so a mistimed capture shows up.
   function automatic row_a_t junk_a(input int k);
      return p2(8'hC0 + k, 8'hD0 + k);
   endfunction

   function automatic row_b_t junk_b(input int k);
      return p4(8'hC0 + k, 8'hD0 + k, 8'hE0 + k, 8'hF0 + k);
   endfunction

   // Present GEMM output for posedge t+k+1 (row j is valid at t+LATENCY+j).
   task automatic drive_a(input int k, input case_a_t v);
      if (k + 1 == L_A)          in_data_a = gemm_a(v.act0);
      else if (k + 1 == L_A + 1) in_data_a = gemm_a(v.act1);
      else                       in_data_a = junk_a(k);
   endtask

   task automatic drive_b(input int k, input case_b_t v);
      in_data_b = junk_b(k);
      for (int j = 0; j < IN_B; j++) if (k + 1 == L_B + j) in_data_b = gemm_b(v.act[j]);
   endtask

   task automatic reset_a();
      resetn_a = 1'b0; start_a = 1'b0; out_ready_a = 1'b0;
      repeat (2) @(negedge clk);
      resetn_a = 1'b1;
   endtask

   // One batch on dut_a; called at a negedge, start is sampled at the next posedge t.
   // Sample k is taken at the negedge after posedge t+k.
   task automatic run_a(input case_a_t v, input string tag);
      int     rows = 0, first_k = -1, stall_left = v.stall, end_k = -1;
      bit     done = 1'b0;
      row_a_t er;
      if (v.pre_reset) reset_a();
      start_a = 1'b1; out_ready_a = 1'b0; in_valid_a = v.valid; in_data_a = junk_a(-1);
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         start_a = 1'b0; out_ready_a = 1'b0;
         if (k == 0) chk({tag, " busy after start"}, int'(busy_a), 1);
         if (out_valid_a) begin
            if (first_k < 0) begin
               first_k = k;
               chk({tag, " first out_valid edge"}, k + 1, L_A + IN_A);
            end
            er = (rows == 0) ? v.res0 : v.res1;
            chk({tag, " out_data"}, int'(out_data_a), int'(er));
            chk({tag, " out_row"}, int'(out_row_a), rows);
            chk({tag, " out_last"}, int'(out_last_a), (rows == IN_A - 1) ? 1 : 0);
            if (stall_left > 0) begin
               stall_left--;
            end else begin
               out_ready_a = 1'b1;
               rows++;
               if (rows == IN_A) begin
                  done  = 1'b1;
                  end_k = k + 1;
                  if (v.start_last) start_a = 1'b1;
               end
            end
         end
         if (k + 1 == v.start2) start_a = 1'b1;
         drive_a(k, v);
      end
      chk({tag, " batch completed"}, int'(done), 1);
      @(negedge clk);
      start_a = 1'b0; out_ready_a = 1'b0;
      chk({tag, " busy low after drain"}, int'(busy_a), 0);
      chk({tag, " out_valid low after drain"}, int'(out_valid_a), 0);
      chk({tag, " busy-fall edge"}, end_k + 1, L_A + 2 * IN_A + v.stall);
      chk({tag, " err_start_dropped"}, int'(err_sd_a), int'(v.exp_sd));
      chk({tag, " err_invalid_capture"}, int'(err_ic_a), int'(v.exp_ic));
   endtask

   // One batch on dut_b with the consumer always ready.
   task automatic run_b(input case_b_t v, input string tag);
      int rows = 0, first_k = -1, end_k = -1;
      bit done = 1'b0;
      start_b = 1'b1; out_ready_b = 1'b1; in_valid_b = 1'b1; in_data_b = junk_b(-1);
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         start_b = 1'b0;
         if (out_valid_b) begin
            if (first_k < 0) begin
               first_k = k;
               chk({tag, " first out_valid edge"}, k + 1, L_B + IN_B);
            end
            chk({tag, " out_data"}, int'(out_data_b), int'(v.res[rows]));
            chk({tag, " out_row"}, int'(out_row_b), rows);
            chk({tag, " out_last"}, int'(out_last_b), (rows == IN_B - 1) ? 1 : 0);
            rows++;
            if (rows == IN_B) begin
               done  = 1'b1;
               end_k = k + 1;
            end
         end
         drive_b(k, v);
      end
      chk({tag, " batch completed"}, int'(done), 1);
      @(negedge clk);
      chk({tag, " busy low after drain"}, int'(busy_b), 0);
      chk({tag, " busy-fall edge"}, end_k + 1, L_B + 2 * IN_B);
      chk({tag, " error flags"}, int'({err_sd_b, err_ic_b}), 0);
   endtask

   case_a_t tbl [4];
   case_b_t cb [2];

   initial begin
      bit seen;
      //           act0       act1       res0        res1       stall st2 last valid prerst sd ic
      tbl[0] = '{p2(2, 5),  p2(3, 2),  p2(6, 10),  p2(9, 4),   0, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{p2(2, 5),  p2(3, 2),  p2(6, 10),  p2(9, 4),   5, -1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{p2(7, 1),  p2(10, 20), p2(21, 2), p2(30, 40), 0,  3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{p2(4, 4),  p2(1, 9),  p2(12, 8),  p2(3, 18),  0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

      cb[0].act[0] = p4(1, 2, 3, 4);  cb[0].res[0] = p4(11, 8, 9, 12);
      cb[0].act[1] = p4(5, 0, 1, 2);  cb[0].res[1] = p4(9, 12, 1, 10);
      cb[0].act[2] = p4(0, 3, 0, 1);  cb[0].res[2] = p4(1, 4, 9, 2);
      cb[1].act[0] = p4(3, 1, 0, 2);  cb[1].res[0] = p4(5, 9, 3, 7);
      cb[1].act[1] = p4(0, 0, 4, 1);  cb[1].res[1] = p4(9, 1, 4, 6);
      cb[1].act[2] = p4(1, 1, 1, 1);  cb[1].res[2] = p4(4, 4, 4, 4);

      resetn_a = 1'b0; start_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = '0;
      resetn_b = 1'b0; start_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0;
      repeat (2) @(negedge clk);
      resetn_a = 1'b1; resetn_b = 1'b1;

      chk("reset busy",      int'(busy_a),      0);
      chk("reset out_valid", int'(out_valid_a), 0);
      chk("reset out_last",  int'(out_last_a),  0);
      chk("reset out_row",   int'(out_row_a),   0);
      chk("reset out_data",  int'(out_data_a),  0);
      chk("reset err flags", int'({err_sd_a, err_ic_a}), 0);
      chk("reset b outputs", int'({busy_b, out_valid_b, out_last_b, out_row_b, err_sd_b, err_ic_b}), 0);
      chk("reset b out_data", int'(out_data_b), 0);

      // Basic batch, stalled consumer, dropped starts, capture before GEMM fill.
      for (int i = 0; i < 4; i++) run_a(tbl[i], $sformatf("vec%0d", i));

      // Reset in the middle of the drain aborts the batch.
      start_a = 1'b1; out_ready_a = 1'b1; in_valid_a = 1'b1; in_data_a = junk_a(-1);
      seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk);
         start_a = 1'b0;
         if (out_valid_a) seen = 1'b1;
         drive_a(k, tbl[0]);
      end
      chk("midreset drain reached", int'(seen), 1);
      chk("midreset row0 data", int'(out_data_a), int'(tbl[0].res0));
      @(negedge clk);
      chk("midreset row1 showing", int'(out_row_a), 1);
      resetn_a = 1'b0;
      @(negedge clk);
      resetn_a = 1'b1; out_ready_a = 1'b0;
      chk("midreset busy",      int'(busy_a),      0);
      chk("midreset out_valid", int'(out_valid_a), 0);
      chk("midreset out_row",   int'(out_row_a),   0);
      chk("midreset out_data",  int'(out_data_a),  0);
      chk("midreset err flags", int'({err_sd_a, err_ic_a}), 0);
      @(negedge clk);
      chk("midreset no partial drain", int'({busy_a, out_valid_a}), 0);
      run_a(tbl[0], "after-reset");

      // Back-to-back batches on the 4x4, 3-row instance.
      resetn_b = 1'b1;
      run_b(cb[0], "b2b first");
      run_b(cb[1], "b2b second");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/gemm_output_collector.md
Name: gemm_output_collector

Overview:
Downstream stage of the fixed-weight systolic GEMM. The GEMM streams one result vector per cycle, and its valid flag stays high permanently after fill. This block uses a start pulse, aligned to the first activation vector of a batch, to capture exactly INPUT_SIZE result vectors at the GEMM's fixed latency. It buffers them as a result matrix and drains them one row per valid/ready handshake to the writeback logic.

Parameters:
SA_SIZE, 4, systolic array dimension (elements per result vector)
INPUT_SIZE, 2, result vectors (rows) per batch; must be >= 1
WEIGHT_ACTIVATION_SIZE, 8, element width in bits
LATENCY, 2*SA_SIZE, GEMM input-to-output latency in cycles; localparam, not overridable

Ports:
clk  in  1  clock, all logic on posedge
resetn  in  1  synchronous active-low reset
start  in  1  pulse; first activation vector of the batch is on the GEMM inputs this cycle
in_valid  in  1  GEMM output_valid
in_data  in  [SA_SIZE] x WEIGHT_ACTIVATION_SIZE  GEMM activation_outputs
busy  out  1  high in any state other than IDLE
out_valid  out  1  row available
out_ready  in  1  consumer accepts row
out_data  out  [SA_SIZE] x WEIGHT_ACTIVATION_SIZE  current row
out_row  out  $clog2(INPUT_SIZE) (min 1)  index of current row
out_last  out  1  current row is INPUT_SIZE-1
err_start_dropped  out  1  sticky; a start was ignored
err_invalid_capture  out  1  sticky; a row was captured while in_valid=0

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE; all counters 0; busy, out_valid, out_last, both err flags = 0; out_data = 0; out_row = 0. Buffer contents are don't-care. Reset mid-operation aborts the batch with no partial drain.
- Cycle numbering: start is sampled high at cycle t.
- States and transitions:
  - IDLE: if start=1, go to WAIT with cnt = LATENCY-1.
  - WAIT: cnt decrements each cycle. At cnt==0, go to CAPTURE with row=0. The first CAPTURE cycle is t+LATENCY.
  - CAPTURE: in_data is written to buf[row] every cycle, so row k is captured at cycle t+LATENCY+k. If in_valid=0 on a capture cycle, the row is still written and err_invalid_capture is set. After row INPUT_SIZE-1, go to DRAIN with rd=0.
  - DRAIN: out_valid=1, out_data=buf[rd], out_row=rd, out_last=(rd==INPUT_SIZE-1). Registered, so first valid at cycle t+LATENCY+INPUT_SIZE. On out_valid&&out_ready, rd increments; on the handshake with out_last=1, go to IDLE.
- Minimum batch occupancy: LATENCY+INPUT_SIZE+INPUT_SIZE cycles, i.e. no backpressure.
- out_data and out_row stay stable while out_valid=1 and out_ready=0.
- out_valid is never high outside DRAIN; out_data holds its last value when out_valid=0.
- start while busy=1 is ignored and sets err_start_dropped. This includes start in the same cycle as the final drain handshake, where busy is still 1.
- Both error flags are sticky and clear only on reset.
- No arithmetic on data; all widths pass through unchanged.
- No in_valid gating of the WAIT count: the latency is fixed by GEMM construction.

Decomposition:
- GEMM_pkg gains:
  - collector_state_t enum {IDLE, WAIT, CAPTURE, DRAIN};
  - function gemm_latency(sa_size) returning 2*sa_size, shared with the GEMM verification harness.
- One sub-module is natural: gemm_row_buffer, an INPUT_SIZE x SA_SIZE register array with one write port and one registered read port.
- The FSM and counters stay in the top module.

Test Plan:
1. SA_SIZE=2, INPUT_SIZE=2, weights [[3,0],[0,2]]. Inputs [2,5] then [3,2], start with the first vector, out_ready=1 -> out_valid at t+6 with rows [6,10] (out_row 0) then [9,4] (out_last=1); busy low at t+8.
2. Same stimulus, out_ready held 0 for 5 cycles -> out_valid and row [6,10] stable throughout; then two handshakes deliver both rows; no error flags.
3. start pulsed again at t+3 (WAIT) and at the final handshake cycle -> both ignored, err_start_dropped=1, exactly 2 rows delivered.
4. start in the first cycle after reset, before GEMM fill -> at least one capture has in_valid=0, so err_invalid_capture=1; all rows are still drained.
5. resetn=0 during DRAIN after row 0 is accepted -> next cycle busy=0, out_valid=0, flags 0. A following start yields a fresh batch beginning at out_row 0.
6. Back-to-back batches (second start one cycle after busy falls), SA_SIZE=4, INPUT_SIZE=3 -> second batch's first row appears exactly LATENCY+3=11 cycles after its start, matching the golden matrix-vector result.
